// File: rtl/div_pkg.sv
// Shared types and op-decoding helpers for the iterative RV32M divider.
package div_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FIX,
        DONE
    } div_state_t;

    function automatic logic div_is_signed(div_op_t op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic div_is_rem(div_op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem, quo} left, trial-subtract the divisor,
// keep the difference when it does not borrow.
module div_step #(
    parameter int unsigned BITS = 32
) (
    input  logic [BITS-1:0] rem,
    input  logic [BITS-1:0] quo,
    input  logic [BITS-1:0] divisor,
    output logic [BITS-1:0] rem_next,
    output logic [BITS-1:0] quo_next
);

    logic [BITS:0] shifted;
    logic [BITS:0] trial;

    // rem < divisor on entry, so the top bit of trial is a clean borrow flag
    always_comb begin
        shifted  = {rem, quo[BITS-1]};
        trial    = shifted - {1'b0, divisor};
        rem_next = trial[BITS] ? shifted[BITS-1:0] : trial[BITS-1:0];
        quo_next = {quo[BITS-2:0], ~trial[BITS]};
    end

endmodule

// File: rtl/div_iter.sv
// Iterative DIV/DIVU/REM/REMU unit: one restoring step per clock, sign fix-up
// in a final cycle, divide-by-zero and signed overflow answered at accept.
module div_iter
    import div_pkg::*;
#(
    parameter int unsigned BITS = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [BITS-1:0] dividend,
    input  logic [BITS-1:0] divisor,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] result
);

    localparam int unsigned CW = $clog2(BITS + 1);
    localparam logic [BITS-1:0] MIN_NEG = {1'b1, {(BITS-1){1'b0}}};

    div_state_t      state, state_nx;
    div_op_t         op_in, op_q;
    logic [CW-1:0]   count;
    logic [BITS-1:0] rem_q, quo_q, dsr_q, result_q;
    logic            qneg, rneg;

    logic            in_signed, dvd_neg, dsr_neg, dsr_zero, ovf, special;
    logic [BITS-1:0] dvd_mag, dsr_mag, special_res;
    logic [BITS-1:0] step_rem, step_quo, fix_quo, fix_rem;

    assign op_in = div_op_t'(op);

    always_comb begin
        in_signed   = div_is_signed(op_in);
        dvd_neg     = in_signed & dividend[BITS-1];
        dsr_neg     = in_signed & divisor[BITS-1];
        dvd_mag     = dvd_neg ? -dividend : dividend;
        dsr_mag     = dsr_neg ? -divisor : divisor;
        dsr_zero    = (divisor == '0);
        ovf         = in_signed && (dividend == MIN_NEG) && (divisor == '1);
        special     = dsr_zero || ovf;
        special_res = '0;
        if (div_is_rem(op_in)) begin
            special_res = dsr_zero ? dividend : '0;
        end else begin
            special_res = dsr_zero ? '1 : dividend;
        end
    end

    div_step #(.BITS(BITS)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dsr_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    always_comb begin
        fix_quo = qneg ? -quo_q : quo_q;
        fix_rem = rneg ? -rem_q : rem_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: if (in_valid) state_nx = special ? DONE : BUSY;
                BUSY: if (count == CW'(1)) state_nx = FIX;
                FIX:  state_nx = DONE;
                DONE: if (out_ready) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        result    = result_q;
    end

    // Datapath is frozen while flushing so an aborted op never touches result_q
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= OP_DIV;
            count    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dsr_q    <= '0;
            result_q <= '0;
            qneg     <= 1'b0;
            rneg     <= 1'b0;
        end else if (!flush) begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q  <= op_in;
                        qneg  <= dvd_neg ^ dsr_neg;
                        rneg  <= dvd_neg;
                        dsr_q <= dsr_mag;
                        quo_q <= dvd_mag;
                        rem_q <= '0;
                        count <= CW'(BITS);
                        if (special) begin
                            result_q <= special_res;
                        end
                    end
                end
                BUSY: begin
                    rem_q <= step_rem;
                    quo_q <= step_quo;
                    count <= count - CW'(1);
                end
                FIX: begin
                    result_q <= div_is_rem(op_q) ? fix_rem : fix_quo;
                end
                default: ;
            endcase
        end
    end

`ifdef FORMAL
    logic [BITS-1:0] f_a, f_b;
    div_op_t         f_op;
    logic            f_live;

    function automatic logic [BITS-1:0] f_ref(div_op_t o, logic [BITS-1:0] a, logic [BITS-1:0] b);
        if (b == '0) return div_is_rem(o) ? a : '1;
        if (div_is_signed(o) && a == MIN_NEG && b == '1) return div_is_rem(o) ? '0 : a;
        if (div_is_signed(o)) return div_is_rem(o) ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
        return div_is_rem(o) ? a % b : a / b;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_live <= 1'b0;
            f_a    <= '0;
            f_b    <= '0;
            f_op   <= OP_DIV;
        end else if (flush) begin
            f_live <= 1'b0;
        end else if (in_valid && in_ready) begin
            f_a    <= dividend;
            f_b    <= divisor;
            f_op   <= op_in;
            f_live <= 1'b1;
        end else if (out_valid && out_ready) begin
            f_live <= 1'b0;
        end
    end

    always_comb begin
        if (reset_n) assert (!(in_ready && out_valid));
    end

    a_hold: assert property (@(posedge clk) disable iff (!reset_n)
        out_valid && !out_ready |=> $stable(result));

    a_ref: assert property (@(posedge clk) disable iff (!reset_n)
        out_valid && f_live |-> result == f_ref(f_op, f_a, f_b));
`endif

endmodule

// File: tb/tb_div_iter.sv
// Randomised self-checking bench for div_iter against a plain-arithmetic
// RISC-V divide model, with directed corner cases, backpressure, flush and reset.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'b00;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;

    div_iter #(.BITS(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .dividend  (dividend),
        .divisor   (divisor),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          due;
        bit          seen;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          npass = 0;
    int          ntotal = 0;
    bit          idle = 1'b1;
    int          acc_cnt = 0;
    logic [31:0] last_res = '0;
    int          last_lat = 0;
    int          rmode = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        ntotal++;
        if (act === req) npass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic bit is_special(logic [1:0] o, logic [31:0] a, logic [31:0] b);
        return (b == 32'h0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] model(logic [1:0] o, logic [31:0] a, logic [31:0] b);
        bit sgn;
        bit remop;
        int sa;
        int sb;
        sgn   = !o[0];
        remop = o[1];
        if (b == 32'h0) return remop ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return remop ? 32'h0 : a;
        sa = a;
        sb = b;
        if (sgn) return remop ? 32'(sa % sb) : 32'(sa / sb);
        return remop ? a % b : a / b;
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       out_ready = ($urandom_range(0, 2) != 0);
            1:       out_ready = 1'b1;
            default: out_ready = 1'b0;
        endcase
    end

    // Single compare process: checks this cycle, then advances the model past the coming edge
    always @(negedge clk) begin
        bit   ev;
        exp_t e;
        if (!reset_n) begin
            q.delete();
            idle = 1'b1;
        end else begin
            ev = (q.size() > 0) && (cyc >= q[0].due);
            chk("in_ready", 32'(in_ready), 32'(idle));
            chk("out_valid", 32'(out_valid), 32'(ev));
            if (out_valid && ev) begin
                chk("result", result, q[0].res);
                if (!q[0].seen) begin
                    q[0].seen = 1'b1;
                    last_lat = cyc - q[0].acc + 1;
                end
            end
            if (flush) begin
                q.delete();
                idle = 1'b1;
            end else if (out_valid && ev && out_ready) begin
                last_res = result;
                void'(q.pop_front());
                idle = 1'b1;
            end else if (in_valid && idle) begin
                e.res  = model(op, dividend, divisor);
                e.acc  = cyc + 1;
                e.due  = cyc + (is_special(op, dividend, divisor) ? 1 : 34);
                e.seen = 1'b0;
                q.push_back(e);
                idle = 1'b0;
                acc_cnt++;
            end
        end
    end

    // Returns in cycle 1 of the accepted op (just after the accept edge)
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int extra);
        int  start;
        bit  got;
        start    = acc_cnt;
        got      = 1'b0;
        in_valid = 1'b1;
        op       = o;
        dividend = a;
        divisor  = b;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (acc_cnt != start) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            ntotal++;
            $display("FAIL accept_timeout: got no accept expected accept (cycle %0d)", cyc);
        end
        for (int i = 0; i < extra; i++) begin
            dividend = $urandom;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (idle && q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            ntotal++;
            $display("FAIL done_timeout: got busy expected idle (cycle %0d)", cyc);
        end
    endtask

    typedef struct {
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          lat;
    } dir_t;

    dir_t dir[10];

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        bit          seen_v;

        dir[0] = '{2'b01, 32'd100, 32'd7, 32'd14, 34};
        dir[1] = '{2'b11, 32'd100, 32'd7, 32'd2, 34};
        dir[2] = '{2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34};
        dir[3] = '{2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34};
        dir[4] = '{2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
        dir[5] = '{2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 34};
        dir[6] = '{2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1};
        dir[7] = '{2'b10, 32'd5, 32'd0, 32'd5, 1};
        dir[8] = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        dir[9] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1};

        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        rmode = 1;
        foreach (dir[i]) begin
            run_op(dir[i].o, dir[i].a, dir[i].b, 0);
            wait_idle();
            chk($sformatf("dir%0d_result", i), last_res, dir[i].r);
            chk($sformatf("dir%0d_latency", i), 32'(last_lat), 32'(dir[i].lat));
        end

        // Backpressure: result must hold while out_ready stays low
        rmode = 2;
        run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 0);
        seen_v = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                seen_v = 1'b1;
                break;
            end
        end
        if (!seen_v) begin
            ntotal++;
            $display("FAIL hold_valid_timeout: got 0 expected 1");
        end
        repeat (5) @(posedge clk);
        #1;
        rmode = 1;
        wait_idle();
        chk("hold_result", last_res, 32'hFFFF_FFFF);
        run_op(2'b01, 32'd50, 32'd5, 0);
        wait_idle();
        chk("after_hold_result", last_res, 32'd10);

        // Flush in cycle 10 of DIVU 1000/3
        run_op(2'b01, 32'd1000, 32'd3, 0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        run_op(2'b01, 32'd9, 32'd3, 0);
        wait_idle();
        chk("post_flush_result", last_res, 32'd3);

        // Asynchronous reset in cycle 20 of an op
        run_op(2'b01, 32'hFFFF_FFFF, 32'd7, 0);
        repeat (19) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_result", result, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Randomised ops with random backpressure and occasional stray in_valid
        rmode = 0;
        for (int n = 0; n < 60; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = $urandom_range(0, 200); rb = $urandom_range(1, 20); end
                3: rb = $urandom_range(1, 3);
                4: rb = 32'hFFFF_FFFF - $urandom_range(0, 5);
                default: ;
            endcase
            run_op(ro, ra, rb, $urandom_range(0, 1));
        end
        rmode = 1;
        wait_idle();

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
